// File: rtl/readout_seq_param.sv
// Pixel-array frame readout sequencer: global reset, exposure, then per-row select/sample/reset/
// sample with ROI windowing, row stride, abort and mux timeout. DUAL_BANK_EN enables L/R banks.
module readout_seq_param #(
    parameter int unsigned ROW_W  = 8,
    parameter int unsigned TW     = 10,
    parameter int unsigned TEXP_W = 20,
    parameter int unsigned MUX_TO = 1024
) (
    input  logic              CLK100MHz,
    input  logic              RESET_N,
    input  logic              TRIGGER,
    input  logic              ABORT,
    input  logic [TW-1:0]     T_GRES,
    input  logic [TW-1:0]     T_SEL,
    input  logic [TW-1:0]     T_SS,
    input  logic [TW-1:0]     T_RES,
`ifdef DUAL_BANK_EN
    input  logic [TW-1:0]     T_RES_R,
`endif
    input  logic [TW-1:0]     T_SR,
    input  logic [TEXP_W-1:0] T_EXP,
    input  logic [ROW_W-1:0]  ROW_FIRST,
    input  logic [ROW_W-1:0]  ROW_LAST,
    input  logic [ROW_W-1:0]  ROW_STEP,
    input  logic              MUX_DONE,
    output logic [ROW_W-1:0]  ROWADD,
    output logic              PIXGLOB_RES,
    output logic              PRECH_COL,
    output logic              SAMP_S,
    output logic              SAMP_R,
    output logic              PIXRES_L,
    output logic              PIXRES_R,
    output logic              COL_L_EN,
    output logic              MUX_START,
    output logic              STDBY,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              MUX_ERR
);

    localparam int unsigned MUX_W = $clog2(MUX_TO + 1);
    localparam int unsigned CW0   = (TEXP_W > TW) ? TEXP_W : TW;
    localparam int unsigned CNT_W = (CW0 > MUX_W) ? CW0 : MUX_W;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUX_LAST = CNT_W'(MUX_TO - 1);

    typedef enum logic [3:0] {
        StIdle, StGres, StExp, StSel, StSs, StRes, StSr, StMux, StNext, StDone
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               trig_q;
    logic [TW-1:0]      t_gres_q, t_sel_q, t_ss_q, t_res_q, t_sr_q;
`ifdef DUAL_BANK_EN
    logic [TW-1:0]      t_res_r_q;
`endif
    logic [TEXP_W-1:0]  t_exp_q;
    logic [ROW_W-1:0]   row_last_q, row_step_q;

    logic [CNT_W-1:0]   len, len_eff;
    logic               phase_end, trig_rise, last_row;
    logic [ROW_W-1:0]   step_eff;
    logic [ROW_W:0]     nxt;

    assign trig_rise = TRIGGER & ~trig_q;

    always_comb begin
        case (state_q)
            StGres:  len = CNT_W'(t_gres_q);
            StExp:   len = CNT_W'(t_exp_q);
            StSel:   len = CNT_W'(t_sel_q);
            StSs:    len = CNT_W'(t_ss_q);
`ifdef DUAL_BANK_EN
            StRes:   len = COL_L_EN ? CNT_W'(t_res_q) : CNT_W'(t_res_r_q);
`else
            StRes:   len = CNT_W'(t_res_q);
`endif
            StSr:    len = CNT_W'(t_sr_q);
            default: len = CNT_ONE;
        endcase
        // A zero-length phase still lasts one cycle.
        len_eff   = (len == '0) ? CNT_ONE : len;
        phase_end = (cnt_q == len_eff - CNT_ONE);
        step_eff  = (row_step_q == '0) ? ROW_W'(1) : row_step_q;
        nxt       = {1'b0, ROWADD} + {1'b0, step_eff};
        last_row  = nxt[ROW_W] || (nxt[ROW_W-1:0] > row_last_q);
    end

    always_ff @(posedge CLK100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            trig_q      <= 1'b0;
            t_gres_q    <= '0;
            t_sel_q     <= '0;
            t_ss_q      <= '0;
            t_res_q     <= '0;
`ifdef DUAL_BANK_EN
            t_res_r_q   <= '0;
`endif
            t_sr_q      <= '0;
            t_exp_q     <= '0;
            row_last_q  <= '0;
            row_step_q  <= '0;
            ROWADD      <= '0;
            PIXGLOB_RES <= 1'b0;
            PRECH_COL   <= 1'b0;
            SAMP_S      <= 1'b0;
            SAMP_R      <= 1'b0;
            PIXRES_L    <= 1'b0;
            PIXRES_R    <= 1'b0;
            COL_L_EN    <= 1'b0;
            MUX_START   <= 1'b0;
            STDBY       <= 1'b1;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            MUX_ERR     <= 1'b0;
        end else begin
            trig_q <= TRIGGER;
            if (ABORT && state_q != StIdle) begin
                // ROWADD deliberately holds so the aborted row stays visible.
                state_q     <= StIdle;
                cnt_q       <= '0;
                PIXGLOB_RES <= 1'b0;
                PRECH_COL   <= 1'b0;
                SAMP_S      <= 1'b0;
                SAMP_R      <= 1'b0;
                PIXRES_L    <= 1'b0;
                PIXRES_R    <= 1'b0;
                COL_L_EN    <= 1'b0;
                MUX_START   <= 1'b0;
                FRAME_DONE  <= 1'b0;
                STDBY       <= 1'b1;
                BUSY        <= 1'b0;
            end else begin
                if (state_q != StIdle) cnt_q <= cnt_q + CNT_ONE;
                case (state_q)
                    StIdle: if (trig_rise) begin
                        t_gres_q    <= T_GRES;
                        t_sel_q     <= T_SEL;
                        t_ss_q      <= T_SS;
                        t_res_q     <= T_RES;
`ifdef DUAL_BANK_EN
                        t_res_r_q   <= T_RES_R;
`endif
                        t_sr_q      <= T_SR;
                        t_exp_q     <= T_EXP;
                        row_last_q  <= ROW_LAST;
                        row_step_q  <= ROW_STEP;
                        ROWADD      <= ROW_FIRST;
                        MUX_ERR     <= 1'b0;
                        COL_L_EN    <= 1'b1;
                        STDBY       <= 1'b0;
                        BUSY        <= 1'b1;
                        PIXGLOB_RES <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StGres;
                    end
                    StGres: if (phase_end) begin
                        PIXGLOB_RES <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= StExp;
                    end
                    StExp: if (phase_end) begin
                        PRECH_COL <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StSel;
                    end
                    StSel: if (phase_end) begin
                        PRECH_COL <= 1'b0;
                        SAMP_S    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StSs;
                    end
                    StSs: if (phase_end) begin
                        SAMP_S   <= 1'b0;
`ifdef DUAL_BANK_EN
                        PIXRES_L <= COL_L_EN;
                        PIXRES_R <= ~COL_L_EN;
`else
                        PIXRES_L <= 1'b1;
`endif
                        cnt_q    <= '0;
                        state_q  <= StRes;
                    end
                    StRes: if (phase_end) begin
                        PIXRES_L <= 1'b0;
                        PIXRES_R <= 1'b0;
                        SAMP_R   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StSr;
                    end
                    StSr: if (phase_end) begin
                        SAMP_R    <= 1'b0;
                        MUX_START <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StMux;
                    end
                    StMux: begin
                        MUX_START <= 1'b0;
                        if (MUX_DONE) begin
                            cnt_q   <= '0;
                            state_q <= StNext;
                        end else if (cnt_q == MUX_LAST) begin
                            MUX_ERR <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= StNext;
                        end
                    end
                    StNext: begin
                        cnt_q <= '0;
                        if (last_row) begin
                            FRAME_DONE <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            ROWADD    <= nxt[ROW_W-1:0];
                            PRECH_COL <= 1'b1;
`ifdef DUAL_BANK_EN
                            COL_L_EN  <= ~COL_L_EN;
`endif
                            state_q   <= StSel;
                        end
                    end
                    StDone: begin
                        FRAME_DONE <= 1'b0;
                        BUSY       <= 1'b0;
                        STDBY      <= 1'b1;
                        COL_L_EN   <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_readout_seq_param.sv
// Bench for readout_seq_param: a frame model fills an expected-row queue; a monitor scores each
// row's control pulse lengths when MUX_START fires. Build with DUAL_BANK_EN for the bank variant.
`timescale 1ns/1ps
module tb_readout_seq_param;
    localparam int ROW_W  = 8;
    localparam int TW     = 10;
    localparam int TEXP_W = 20;
    localparam int MUX_TO = 40;

    logic clk = 1'b0;
    logic rst_n;
    logic TRIGGER, ABORT, MUX_DONE;
    logic [TW-1:0] T_GRES, T_SEL, T_SS, T_RES, T_RES_R, T_SR;
    logic [TEXP_W-1:0] T_EXP;
    logic [ROW_W-1:0] ROW_FIRST, ROW_LAST, ROW_STEP, ROWADD;
    logic PIXGLOB_RES, PRECH_COL, SAMP_S, SAMP_R, PIXRES_L, PIXRES_R, COL_L_EN, MUX_START;
    logic STDBY, BUSY, FRAME_DONE, MUX_ERR;

    always #5 clk = ~clk;

    readout_seq_param #(.ROW_W(ROW_W), .TW(TW), .TEXP_W(TEXP_W), .MUX_TO(MUX_TO)) dut (
        .CLK100MHz(clk), .RESET_N(rst_n), .TRIGGER(TRIGGER), .ABORT(ABORT),
        .T_GRES(T_GRES), .T_SEL(T_SEL), .T_SS(T_SS), .T_RES(T_RES),
`ifdef DUAL_BANK_EN
        .T_RES_R(T_RES_R),
`endif
        .T_SR(T_SR), .T_EXP(T_EXP), .ROW_FIRST(ROW_FIRST), .ROW_LAST(ROW_LAST),
        .ROW_STEP(ROW_STEP), .MUX_DONE(MUX_DONE), .ROWADD(ROWADD), .PIXGLOB_RES(PIXGLOB_RES),
        .PRECH_COL(PRECH_COL), .SAMP_S(SAMP_S), .SAMP_R(SAMP_R), .PIXRES_L(PIXRES_L),
        .PIXRES_R(PIXRES_R), .COL_L_EN(COL_L_EN), .MUX_START(MUX_START), .STDBY(STDBY),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .MUX_ERR(MUX_ERR)
    );

    typedef struct {
        int row;
        int prech;
        int samps;
        int resl;
        int resr;
    } row_t;

    row_t exp_q[$];
    row_t mon_e;
    int checks = 0, failures = 0;
    int frame_cnt = 0, cyc = 0, mux_start_cyc = 0, err_cyc = -1;
    int n_prech = 0, n_samps = 0, n_resl = 0, n_resr = 0;
    logic err_q = 1'b0;
    int mux_delay = 3, mux_cd = 0;

    // Monitor / scoreboard: counts control high-cycles per row, scores at MUX_START.
    always @(negedge clk) begin
        cyc++;
        if (FRAME_DONE === 1'b1) frame_cnt++;
        if (MUX_ERR === 1'b1 && err_q !== 1'b1) err_cyc = cyc;
        err_q = MUX_ERR;
        if (STDBY !== 1'b0) begin
            n_prech = 0; n_samps = 0; n_resl = 0; n_resr = 0;
        end else begin
            n_prech += int'(PRECH_COL);
            n_samps += int'(SAMP_S);
            n_resl  += int'(PIXRES_L);
            n_resr  += int'(PIXRES_R);
        end
        if (MUX_START === 1'b1) begin
            mux_start_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL row_unexpected: got row %0d, required no further rows", ROWADD);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(ROWADD) != mon_e.row || n_prech != mon_e.prech
                    || n_samps != mon_e.samps || n_resl != mon_e.resl || n_resr != mon_e.resr)
                begin
                    failures++;
                    $display("FAIL row_record: got row=%0d prech=%0d samps=%0d resl=%0d resr=%0d, required row=%0d prech=%0d samps=%0d resl=%0d resr=%0d",
                             ROWADD, n_prech, n_samps, n_resl, n_resr, mon_e.row,
                             mon_e.prech, mon_e.samps, mon_e.resl, mon_e.resr);
                end
            end
            n_prech = 0; n_samps = 0; n_resl = 0; n_resr = 0;
        end
    end

    // Column-mux responder: MUX_DONE mux_delay cycles after MUX_START; 0 means never.
    always @(negedge clk) begin
        MUX_DONE = 1'b0;
        if (mux_cd > 0) begin
            mux_cd--;
            if (mux_cd == 0) MUX_DONE = 1'b1;
        end
        if (MUX_START === 1'b1 && mux_delay > 0) mux_cd = mux_delay;
    end

    function automatic int eff(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    // Frame model: expected per-row pulse lengths for a given ROI and timing.
    task automatic push_frame(input int first, input int last, input int step, input int tsel,
                              input int tss, input int tres, input int tresr);
        int r;
        bit left;
        row_t e;
        r = first;
        left = 1'b1;
        for (int k = 0; k < 300; k++) begin
            e.row = r;
            e.prech = eff(tsel);
            e.samps = eff(tss);
`ifdef DUAL_BANK_EN
            e.resl = left ? eff(tres) : 0;
            e.resr = left ? 0 : eff(tresr);
`else
            e.resl = eff(tres);
            e.resr = 0;
`endif
            exp_q.push_back(e);
            r = r + ((step == 0) ? 1 : step);
            left = !left;
            if (r > last || r > 255) break;
        end
    endtask

    task automatic set_frame(input int first, input int last, input int step, input int tsel,
                             input int tss, input int tres, input int tresr, input int texp);
        T_GRES = TW'(2);
        T_SR = TW'(2);
        T_SEL = TW'(tsel);
        T_SS = TW'(tss);
        T_RES = TW'(tres);
        T_RES_R = TW'(tresr);
        T_EXP = TEXP_W'(texp);
        ROW_FIRST = ROW_W'(first);
        ROW_LAST = ROW_W'(last);
        ROW_STEP = ROW_W'(step);
    endtask

    task automatic pulse_trigger();
        @(posedge clk); #1 TRIGGER = 1'b1;
        @(posedge clk); #1 TRIGGER = 1'b0;
    endtask

    task automatic wait_frame(input int f0, input int budget);
        for (int i = 0; i < budget && frame_cnt == f0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; TRIGGER = 1'b0; ABORT = 1'b0;
        set_frame(0, 0, 1, 2, 2, 2, 2, 2);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (STDBY !== 1'b1 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: got STDBY=%b BUSY=%b, required 1 0", STDBY, BUSY);
        end
        checks++;
        if (ROWADD !== '0) begin
            failures++; $display("FAIL reset_rowadd: got %0d, required 0", ROWADD);
        end
        checks++;
        if ({PIXGLOB_RES, PRECH_COL, SAMP_S, SAMP_R, PIXRES_L, PIXRES_R, COL_L_EN, MUX_START,
             FRAME_DONE, MUX_ERR} !== 10'b0) begin
            failures++; $display("FAIL reset_controls: got nonzero controls, required all 0");
        end
        @(negedge clk) rst_n = 1'b1;
        // Mid-frame asynchronous reset during exposure.
        set_frame(5, 9, 1, 2, 2, 2, 2, 100);
        pulse_trigger();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (BUSY !== 1'b1 || ROWADD !== 8'd5) begin
            failures++;
            $display("FAIL exp_rowadd: got BUSY=%b ROWADD=%0d, required 1 5", BUSY, ROWADD);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (STDBY !== 1'b1 || BUSY !== 1'b0 || ROWADD !== '0) begin
            failures++;
            $display("FAIL async_reset: got STDBY=%b BUSY=%b ROWADD=%0d, required 1 0 0",
                     STDBY, BUSY, ROWADD);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int f0;
        f0 = frame_cnt;
        mux_delay = 3;
        push_frame(0, 3, 1, 2, 2, 2, 2);
        set_frame(0, 3, 1, 2, 2, 2, 2, 100);
        pulse_trigger();
        wait_frame(f0, 3000);
        checks++;
        if (frame_cnt != f0 + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_frame: got frames=%0d rows_left=%0d, required 1 0",
                     frame_cnt - f0, exp_q.size());
        end
        checks++;
        if (MUX_ERR !== 1'b0 || STDBY !== 1'b1) begin
            failures++;
            $display("FAIL basic_status: got MUX_ERR=%b STDBY=%b, required 0 1", MUX_ERR, STDBY);
        end
    endtask

    task automatic test_stride();
        int f0;
        int cfg [3][3] = '{'{10, 20, 4}, '{250, 255, 8}, '{9, 3, 0}};
        for (int i = 0; i < 3; i++) begin
            f0 = frame_cnt;
            push_frame(cfg[i][0], cfg[i][1], cfg[i][2], 2, 2, 2, 2);
            set_frame(cfg[i][0], cfg[i][1], cfg[i][2], 2, 2, 2, 2, 3);
            pulse_trigger();
            wait_frame(f0, 3000);
            checks++;
            if (frame_cnt != f0 + 1 || exp_q.size() != 0) begin
                failures++;
                $display("FAIL stride_frame[%0d]: got frames=%0d rows_left=%0d, required 1 0",
                         i, frame_cnt - f0, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_timeout();
        int f0;
        f0 = frame_cnt;
        mux_delay = 0;
        err_cyc = -1;
        push_frame(7, 7, 1, 2, 2, 2, 2);
        set_frame(7, 7, 1, 2, 2, 2, 2, 4);
        pulse_trigger();
        wait_frame(f0, 3000);
        checks++;
        if (err_cyc - mux_start_cyc != MUX_TO) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles, required %0d",
                     err_cyc - mux_start_cyc, MUX_TO);
        end
        checks++;
        if (frame_cnt != f0 + 1 || exp_q.size() != 0 || MUX_ERR !== 1'b1) begin
            failures++;
            $display("FAIL timeout_frame: got frames=%0d rows_left=%0d MUX_ERR=%b, required 1 0 1",
                     frame_cnt - f0, exp_q.size(), MUX_ERR);
        end
        mux_delay = 3;
    endtask

    task automatic test_abort();
        int f0;
        bit found;
        f0 = frame_cnt;
        push_frame(0, 1, 1, 2, 2, 2, 2);
        set_frame(0, 3, 1, 2, 2, 2, 2, 10);
        pulse_trigger();
        checks++;
        if (MUX_ERR !== 1'b0 || PIXGLOB_RES !== 1'b1 || ROWADD !== 8'd0) begin
            failures++;
            $display("FAIL accept_clear: got MUX_ERR=%b PIXGLOB_RES=%b ROWADD=%0d, required 0 1 0",
                     MUX_ERR, PIXGLOB_RES, ROWADD);
        end
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (ROWADD === 8'd2 && SAMP_S === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL abort_reach: got no row-2 SS, required one");
        end
        ABORT = 1'b1;
        @(posedge clk); #1 ABORT = 1'b0;
        @(negedge clk);
        checks++;
        if (SAMP_S !== 1'b0 || STDBY !== 1'b1 || BUSY !== 1'b0 || ROWADD !== 8'd2) begin
            failures++;
            $display("FAIL abort_state: got SAMP_S=%b STDBY=%b BUSY=%b ROWADD=%0d, required 0 1 0 2",
                     SAMP_S, STDBY, BUSY, ROWADD);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (frame_cnt != f0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_no_done: got frames=%0d rows_left=%0d, required 0 0",
                     frame_cnt - f0, exp_q.size());
            exp_q.delete();
        end
        push_frame(0, 3, 1, 2, 2, 2, 2);
        pulse_trigger();
        checks++;
        if (ROWADD !== 8'd0 || PIXGLOB_RES !== 1'b1) begin
            failures++;
            $display("FAIL restart_row: got ROWADD=%0d PIXGLOB_RES=%b, required 0 1",
                     ROWADD, PIXGLOB_RES);
        end
        wait_frame(f0, 3000);
        checks++;
        if (frame_cnt != f0 + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL restart_frame: got frames=%0d rows_left=%0d, required 1 0",
                     frame_cnt - f0, exp_q.size());
        end
    endtask

    task automatic test_retrigger();
        int f0;
        f0 = frame_cnt;
        push_frame(0, 1, 1, 0, 2, 2, 2);
        set_frame(0, 1, 1, 0, 2, 2, 2, 20);
        pulse_trigger();
        repeat (30) @(posedge clk);
        #1 ROW_LAST = 8'd5;
        pulse_trigger();
        wait_frame(f0, 3000);
        checks++;
        if (frame_cnt != f0 + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL retrig_frame: got frames=%0d rows_left=%0d, required 1 0",
                     frame_cnt - f0, exp_q.size());
            exp_q.delete();
        end
        repeat (30) @(negedge clk);
        checks++;
        if (STDBY !== 1'b1 || frame_cnt != f0 + 1) begin
            failures++;
            $display("FAIL retrig_ignored: got STDBY=%b frames=%0d, required 1 1",
                     STDBY, frame_cnt - f0);
        end
    endtask

    task automatic test_banks();
        int f0;
        f0 = frame_cnt;
        push_frame(0, 3, 1, 2, 2, 56, 20);
        set_frame(0, 3, 1, 2, 2, 56, 20, 5);
        pulse_trigger();
        wait_frame(f0, 3000);
        checks++;
        if (frame_cnt != f0 + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL banks_frame: got frames=%0d rows_left=%0d, required 1 0",
                     frame_cnt - f0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride();
        test_timeout();
        test_abort();
        test_retrigger();
        test_banks();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
